// File: rtl/cpu_pkg.sv
// Shared opcode, skip-condition and FSM state definitions for the fetch/decode front end.
package cpu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned SKC_W = 2;

  localparam logic [OPC_W-1:0] OP_SKIP = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [SKC_W-1:0] {
    SKC_NEG   = 2'b00,
    SKC_ZERO  = 2'b01,
    SKC_POS   = 2'b10,
    SKC_NEVER = 2'b11
  } skip_cond_t;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    ISSUE_EXEC = 3'd2,
    ISSUE_SKIP = 3'd3,
    HALT       = 3'd4
  } fd_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the opcode and skip-condition field (top bits of the instruction word).
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W+SKC_W-1:0] instr_hi_i,
  output logic                   is_skip_c,
  output logic                   is_halt_c,
  output skip_cond_t             skip_cond_c
);

  logic [OPC_W-1:0] opcode;

  always_comb begin
    opcode      = instr_hi_i[OPC_W+SKC_W-1:SKC_W];
    is_skip_c   = (opcode == OP_SKIP);
    is_halt_c   = (opcode == OP_HLT);
    skip_cond_c = skip_cond_t'(instr_hi_i[SKC_W-1:0]);
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// PC owner: fetches over req/ack, decodes, issues to execute or skip stage.
// Optional PC_WRAP_TRAP_EN: PC increment from all-ones halts instead of wrapping.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              exec_valid,
  input  logic              exec_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              skip_valid,
  output logic [1:0]        skip_cond,
  input  logic              skip_done,
  input  logic              skip_taken,
  output logic              halted
);

`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              exec_valid_q, exec_valid_d;
  logic              skip_valid_q, skip_valid_d;
  skip_cond_t        skip_cond_q, skip_cond_d;
  logic              halted_q, halted_d;

  logic              dec_is_skip;
  logic              dec_is_halt;
  skip_cond_t        dec_cond;
  logic              pc_at_max;

  instr_decoder u_dec (
    .instr_hi_i  (ir_q[DATA_W-1 -: (OPC_W+SKC_W)]),
    .is_skip_c   (dec_is_skip),
    .is_halt_c   (dec_is_halt),
    .skip_cond_c (dec_cond)
  );

  assign pc_at_max = (pc_q == {ADDR_W{1'b1}});

  // Next state / PC; registered outputs are derived from the next state so they align with it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;

    unique case (state_q)
      FETCH: begin
        // mem_req_q gates the ack so the idle cycle right after reset cannot accept data
        if (mem_req_q && mem_ack) begin
          ir_d = mem_rdata;
          if (TRAP_EN && pc_at_max) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        if (dec_is_skip)      state_d = ISSUE_SKIP;
        else if (dec_is_halt) state_d = HALT;
        else                  state_d = ISSUE_EXEC;
      end
      ISSUE_EXEC: begin
        if (exec_ready) begin
          if (branch_valid) pc_d = branch_target;
          state_d = FETCH;
        end
      end
      ISSUE_SKIP: begin
        if (skip_done) begin
          state_d = FETCH;
          if (skip_taken && (skip_cond_q != SKC_NEVER)) begin
            if (TRAP_EN && pc_at_max) state_d = HALT;
            else                      pc_d    = pc_q + ADDR_W'(1);
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    mem_req_d    = (state_d == FETCH);
    mem_addr_d   = mem_req_d ? pc_d : '0;
    exec_valid_d = (state_d == ISSUE_EXEC);
    skip_valid_d = (state_d == ISSUE_SKIP);
    skip_cond_d  = skip_valid_d ? dec_cond : SKC_NEG;
    halted_d     = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      exec_valid_q <= 1'b0;
      skip_valid_q <= 1'b0;
      skip_cond_q  <= SKC_NEG;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      exec_valid_q <= exec_valid_d;
      skip_valid_q <= skip_valid_d;
      skip_cond_q  <= skip_cond_d;
      halted_q     <= halted_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign ir         = ir_q;
  assign exec_valid = exec_valid_q;
  assign skip_valid = skip_valid_q;
  assign skip_cond  = skip_cond_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomized bench for fetch_decode_unit: the bench plays memory, execute and skip stages
// and tracks the architectural PC with an instruction-level model.
module tb_fetch_decode_unit;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] RST_PC = 12'h000;

`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              exec_valid;
  logic              exec_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              skip_valid;
  logic [1:0]        skip_cond;
  logic              skip_done;
  logic              skip_taken;
  logic              halted;

  fetch_decode_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .exec_valid    (exec_valid),
    .exec_ready    (exec_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .skip_valid    (skip_valid),
    .skip_cond     (skip_cond),
    .skip_done     (skip_done),
    .skip_taken    (skip_taken),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // architectural model state
  logic [ADDR_W-1:0] m_pc;
  bit                m_halt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mem_ack = 1'b0; exec_ready = 1'b0; branch_valid = 1'b0;
    skip_done = 1'b0; skip_taken = 1'b0;
  endtask

  task automatic model_inc();
    if (TRAP && m_pc == 12'hFFF) m_halt = 1'b1;
    else                         m_pc = m_pc + 12'd1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    mem_rdata = '0; branch_target = '0;
    repeat (2) tick();
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_ir",    32'(ir), 32'd0);
    check("rst_outs",  32'({exec_valid, skip_valid, skip_cond, halted}), 32'd0);
    rst = 1'b1;
    m_pc = RST_PC;
    m_halt = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!mem_req && k < 8) begin
      tick();
      k++;
    end
    check("req_timeout", 32'(mem_req), 32'd1);
  endtask

  // Halted: no requests for 20 cycles despite input noise, then reset restarts at RESET_PC.
  task automatic halt_check();
    int bad = 0;
    check("halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom); exec_ready = 1'($urandom); skip_done = 1'($urandom);
      tick();
      if (mem_req || !halted || exec_valid || skip_valid) bad++;
    end
    check("halt_quiet", 32'(bad), 32'd0);
    do_reset();
  endtask

  task automatic do_instr(input logic [15:0] ins, input int ack_dly, input int rdy_dly,
                          input bit br, input logic [ADDR_W-1:0] tgt, input bit taken);
    logic [3:0] op;
    logic [1:0] cond;
    op   = ins[15:12];
    cond = ins[11:10];
    wait_req();
    check("mem_addr", 32'(mem_addr), 32'(m_pc));
    for (int i = 0; i < ack_dly; i++) begin
      mem_rdata = 16'($urandom); exec_ready = 1'($urandom); skip_done = 1'($urandom);
      tick();
      check("req_hold", 32'({mem_req, mem_addr}), 32'({1'b1, m_pc}));
    end
    clear_inputs();
    mem_ack = 1'b1; mem_rdata = ins;
    tick();
    clear_inputs();
    mem_rdata = 16'($urandom);
    model_inc();
    if (m_halt) begin
      halt_check();
      return;
    end
    check("ir", 32'(ir), 32'(ins));
    check("decode_idle", 32'({mem_req, exec_valid, skip_valid, halted}), 32'd0);
    tick();
    if (op == 4'hF) begin
      check("hlt_req", 32'(mem_req), 32'd0);
      halt_check();
      return;
    end
    if (op == 4'hE) begin
      check("skip_issue", 32'({skip_valid, exec_valid, skip_cond}), 32'({2'b10, cond}));
      for (int i = 0; i < rdy_dly; i++) begin
        exec_ready = 1'($urandom); branch_valid = 1'($urandom); mem_ack = 1'($urandom);
        skip_taken = 1'($urandom);
        tick();
        check("skip_hold", 32'({skip_valid, skip_cond, mem_req}), 32'({1'b1, cond, 1'b0}));
      end
      clear_inputs();
      branch_valid = 1'($urandom); branch_target = 12'($urandom);
      skip_done = 1'b1; skip_taken = taken;
      tick();
      clear_inputs();
      if (taken && cond != 2'b11) model_inc();
      if (m_halt) halt_check();
    end else begin
      check("exec_issue", 32'({exec_valid, skip_valid}), 32'b10);
      for (int i = 0; i < rdy_dly; i++) begin
        branch_valid = 1'($urandom); branch_target = 12'($urandom);
        skip_done = 1'($urandom); skip_taken = 1'b1; mem_ack = 1'($urandom);
        tick();
        check("exec_hold", 32'({exec_valid, mem_req}), 32'b10);
      end
      clear_inputs();
      exec_ready = 1'b1; branch_valid = br; branch_target = tgt;
      tick();
      clear_inputs();
      if (br) m_pc = tgt;
    end
  endtask

  logic [15:0]       r_ins;
  logic [ADDR_W-1:0] r_tgt;
  int                r;

  initial begin
    rst = 1'b0;
    clear_inputs();
    mem_rdata = '0; branch_target = '0;
    do_reset();

    // plain exec, ack on the first request cycle
    do_instr(16'h1005, 0, 0, 1'b0, 12'h000, 1'b0);
    // skip cond ZERO taken, then not taken, then NEVER with taken asserted
    do_instr(16'hE400, 1, 2, 1'b0, 12'h000, 1'b1);
    do_instr(16'hE400, 0, 0, 1'b0, 12'h000, 1'b0);
    do_instr(16'hEC00, 0, 1, 1'b0, 12'h000, 1'b1);
    // branch, with stalls carrying branch_valid noise
    do_instr(16'h3123, 2, 3, 1'b1, 12'h0A0, 1'b0);
    do_instr(16'h2000, 0, 0, 1'b0, 12'h000, 1'b0);
    // fetch from all-ones: wrap or trap
    do_instr(16'h4000, 0, 0, 1'b1, 12'hFFF, 1'b0);
    do_instr(16'h5000, 0, 0, 1'b0, 12'h000, 1'b0);
    // taken skip with PC at all-ones after fetch
    do_instr(16'h4000, 0, 0, 1'b1, 12'hFFE, 1'b0);
    do_instr(16'hE800, 0, 0, 1'b0, 12'h000, 1'b1);
    do_instr(16'h6000, 0, 0, 1'b0, 12'h000, 1'b0);
    // HLT
    do_instr(16'hF000, 0, 0, 1'b0, 12'h000, 1'b0);
    do_instr(16'h1000, 0, 0, 1'b0, 12'h000, 1'b0);

    // reset mid-fetch drops the request asynchronously
    do_instr(16'h1000, 0, 0, 1'b1, 12'h123, 1'b0);
    wait_req();
    #2 rst = 1'b0;
    #1 check("async_rst_req", 32'(mem_req), 32'd0);
    do_reset();
    do_instr(16'h7000, 1, 0, 1'b0, 12'h000, 1'b0);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      r_ins = {4'hE, 12'($urandom)};
      else if (r < 33) r_ins = {4'hF, 12'($urandom)};
      else             r_ins = {4'($urandom_range(0, 13)), 12'($urandom)};
      r_tgt = ($urandom_range(0, 3) == 0) ? (12'hFFC + 12'($urandom_range(0, 3))) : 12'($urandom);
      do_instr(r_ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 2) == 0), r_tgt, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
